rate_generator: RTL and testbench

- Multi-channel programmable successor to the single fixed 100 Hz divider.
- From the 25 MHz system clock, each of NUM_CH channels independently produces either a 50%-duty slow clock or a one-cycle tick strobe.
- Each channel's divisor and mode are reprogrammable at runtime through a valid/ready config port. New settings take effect glitch-free at that channel's next terminal count.
- Feeds motor step timing, sensor polling and UI refresh logic.

---
 rtl/rate_generator.sv | 120 ++++++++++++
 tb/tb_rate_generator.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_generator.sv
// Multi-channel programmable divider: per-channel slow clock or tick strobe.
// Divisor/mode reprogrammed via valid/ready, applied at next terminal count.
module rate_generator #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 17,
   parameter int DEFAULT_DIV = 124999,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_mode,
   input  logic [NUM_CH-1:0] ch_enable,
   input  logic              sync_restart,
   output logic [NUM_CH-1:0] slow_clock,
   output logic [NUM_CH-1:0] tick
);

   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [CNT_W-1:0]  div_act_q [NUM_CH];
   logic [CNT_W-1:0]  div_act_d [NUM_CH];
   logic [CNT_W-1:0]  div_sh_q [NUM_CH];
   logic [CNT_W-1:0]  div_sh_d [NUM_CH];
   logic [NUM_CH-1:0] mode_act_q, mode_act_d;
   logic [NUM_CH-1:0] mode_sh_q, mode_sh_d;
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] slow_q, slow_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] wr;

   // Out-of-range channel indices are always ready and silently dropped.
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) cfg_ready = !pend_q[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]      = cnt_q[i];
         div_act_d[i]  = div_act_q[i];
         div_sh_d[i]   = div_sh_q[i];
         mode_act_d[i] = mode_act_q[i];
         mode_sh_d[i]  = mode_sh_q[i];
         pend_d[i]     = pend_q[i];
         slow_d[i]     = slow_q[i];
         tick_d[i]     = tick_q[i];
         if (sync_restart || !ch_enable[i]) begin
            cnt_d[i]  = '0;
            slow_d[i] = 1'b0;
            tick_d[i] = 1'b0;
            if (pend_q[i]) begin
               div_act_d[i]  = div_sh_q[i];
               mode_act_d[i] = mode_sh_q[i];
               pend_d[i]     = 1'b0;
            end
         end else if (cnt_q[i] == div_act_q[i]) begin
            cnt_d[i]  = '0;
            tick_d[i] = mode_act_q[i];
            slow_d[i] = mode_act_q[i] ? slow_q[i] : !slow_q[i];
            if (pend_q[i]) begin
               div_act_d[i]  = div_sh_q[i];
               mode_act_d[i] = mode_sh_q[i];
               pend_d[i]     = 1'b0;
               if (mode_sh_q[i]) slow_d[i] = 1'b0;
            end
         end else begin
            cnt_d[i]  = cnt_q[i] + 1'b1;
            tick_d[i] = 1'b0;
         end
         // A write only lands when pend was clear, so it never races an apply.
         if (wr[i]) begin
            div_sh_d[i]  = cfg_div;
            mode_sh_d[i] = cfg_mode;
            pend_d[i]    = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]     <= '0;
            div_act_q[i] <= CNT_W'(DEFAULT_DIV);
            div_sh_q[i]  <= CNT_W'(DEFAULT_DIV);
         end
         mode_act_q <= '0;
         mode_sh_q  <= '0;
         pend_q     <= '0;
         slow_q     <= '0;
         tick_q     <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]     <= cnt_d[i];
            div_act_q[i] <= div_act_d[i];
            div_sh_q[i]  <= div_sh_d[i];
         end
         mode_act_q <= mode_act_d;
         mode_sh_q  <= mode_sh_d;
         pend_q     <= pend_d;
         slow_q     <= slow_d;
         tick_q     <= tick_d;
      end
   end

   assign slow_clock = slow_q;
   assign tick       = tick_q;

endmodule

// File: tb/tb_rate_generator.sv
// Scoreboard bench for rate_generator (3 channels, 4-bit counters, D=3).
module tb_rate_generator;

   logic       clk;
   logic       reset;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [1:0] cfg_ch;
   logic [3:0] cfg_div;
   logic       cfg_mode;
   logic [2:0] en;
   logic       sync;
   logic [2:0] slow;
   logic [2:0] tick;

   int pass_cnt;
   int total_cnt;
   logic [5:0] exp_q[$];
   logic [5:0] e;

   rate_generator #(
      .NUM_CH(3),
      .CNT_W(4),
      .DEFAULT_DIV(3)
   ) dut (
      .clock(clk),
      .reset(reset),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch),
      .cfg_div(cfg_div),
      .cfg_mode(cfg_mode),
      .ch_enable(en),
      .sync_restart(sync),
      .slow_clock(slow),
      .tick(tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Default-divisor clock-mode level after edge k since reset.
   function automatic logic d(int k);
      return ((k / 4) % 2) == 1;
   endfunction

   task automatic do_reset();
      reset     = 1'b1;
      cfg_valid = 1'b0;
      cfg_ch    = 2'd0;
      cfg_div   = 4'd0;
      cfg_mode  = 1'b0;
      en        = 3'b111;
      sync      = 1'b0;
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++;
      if ({slow, tick} !== 6'b0) begin
         $display("FAIL reset_out got=%b want=000000", {slow, tick});
      end else pass_cnt++;
      total_cnt++;
      if (cfg_ready !== 1'b1) begin
         $display("FAIL reset_ready got=%b want=1", cfg_ready);
      end else pass_cnt++;
      for (int k = 1; k <= 16; k++) begin
         exp_q.push_back({d(k), d(k), d(k), 3'b000});
      end
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total_cnt++;
         if ({slow, tick} !== e) begin
            $display("FAIL reset_run k=%0d got=%b want=%b", k, {slow, tick}, e);
         end else pass_cnt++;
      end
   endtask

   task automatic test_tick_reprogram();
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         exp_q.push_back({d(k), 1'b0, d(k),
                          1'b0, (k >= 5 && k % 2 == 0), 1'b0});
      end
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total_cnt++;
         if ({slow, tick} !== e) begin
            $display("FAIL tick_reprog k=%0d got=%b want=%b", k, {slow, tick}, e);
         end else pass_cnt++;
         if (k == 1) begin
            cfg_ch = 2'd1; cfg_div = 4'd1; cfg_mode = 1'b1; cfg_valid = 1'b1;
         end else if (k == 2) cfg_valid = 1'b0;
         if (k >= 2 && k <= 4) begin
            #1;
            total_cnt++;
            if (cfg_ready !== (k == 4)) begin
               $display("FAIL tick_ready k=%0d got=%b want=%b", k, cfg_ready, (k == 4));
            end else pass_cnt++;
         end
      end
   endtask

   task automatic test_zero_div();
      do_reset();
      cfg_ch = 2'd0; cfg_div = 4'd0; cfg_mode = 1'b1; cfg_valid = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         exp_q.push_back({d(k), d(k), (k >= 10 && k % 2 == 0),
                          1'b0, 1'b0, (k >= 5 && k <= 9)});
      end
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total_cnt++;
         if ({slow, tick} !== e) begin
            $display("FAIL zero_div k=%0d got=%b want=%b", k, {slow, tick}, e);
         end else pass_cnt++;
         if (k == 1 || k == 8) cfg_valid = 1'b0;
         if (k == 7) begin
            cfg_div = 4'd0; cfg_mode = 1'b0; cfg_valid = 1'b1;
         end
      end
   endtask

   task automatic test_disabled_cfg();
      do_reset();
      en = 3'b101;
      cfg_ch = 2'd1; cfg_div = 4'd5; cfg_mode = 1'b1; cfg_valid = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         exp_q.push_back({d(k), 1'b0, d(k),
                          1'b0, (k == 9 || k == 15), 1'b0});
      end
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total_cnt++;
         if ({slow, tick} !== e) begin
            $display("FAIL disabled k=%0d got=%b want=%b", k, {slow, tick}, e);
         end else pass_cnt++;
         if (k == 1) cfg_valid = 1'b0;
         if (k == 3) en = 3'b111;
         if (k == 1 || k == 2) begin
            #1;
            total_cnt++;
            if (cfg_ready !== (k == 2)) begin
               $display("FAIL disabled_ready k=%0d got=%b want=%b", k, cfg_ready, (k == 2));
            end else pass_cnt++;
         end
      end
   endtask

   task automatic test_terminal_cfg();
      logic s0;
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         s0 = (k < 8) ? d(k) : ((((k - 8) / 2) % 2) == 1);
         exp_q.push_back({d(k), d(k), s0, 3'b000});
      end
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total_cnt++;
         if ({slow, tick} !== e) begin
            $display("FAIL term_cfg k=%0d got=%b want=%b", k, {slow, tick}, e);
         end else pass_cnt++;
         if (k == 3) begin
            cfg_ch = 2'd0; cfg_div = 4'd1; cfg_mode = 1'b0; cfg_valid = 1'b1;
         end
         if (k == 4) cfg_valid = 1'b0;
         if (k >= 4 && k <= 8) begin
            #1;
            total_cnt++;
            if (cfg_ready !== (k == 8)) begin
               $display("FAIL term_ready k=%0d got=%b want=%b", k, cfg_ready, (k == 8));
            end else pass_cnt++;
         end
      end
   endtask

   task automatic test_sync_restart();
      logic s0, s1;
      do_reset();
      en = 3'b101;
      for (int k = 1; k <= 16; k++) begin
         s0 = (k < 7) ? d(k) : ((((k - 7) / 4) % 2) == 1);
         s1 = (k < 7) ? (k == 6) : s0;
         exp_q.push_back({s0, s1, s0, 3'b000});
      end
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total_cnt++;
         if ({slow, tick} !== e) begin
            $display("FAIL sync k=%0d got=%b want=%b", k, {slow, tick}, e);
         end else pass_cnt++;
         if (k == 2) en = 3'b111;
         if (k == 6) sync = 1'b1;
         if (k == 7) sync = 1'b0;
      end
   endtask

   task automatic test_reset_oor();
      do_reset();
      cfg_ch = 2'd0; cfg_div = 4'd1; cfg_mode = 1'b1; cfg_valid = 1'b1;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      #1;
      total_cnt++;
      if (cfg_ready !== 1'b0) begin
         $display("FAIL pend_set got=%b want=0", cfg_ready);
      end else pass_cnt++;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      total_cnt++;
      if ({slow, tick} !== 6'b0) begin
         $display("FAIL midreset_out got=%b want=000000", {slow, tick});
      end else pass_cnt++;
      total_cnt++;
      if (cfg_ready !== 1'b1) begin
         $display("FAIL midreset_ready got=%b want=1", cfg_ready);
      end else pass_cnt++;
      cfg_ch = 2'd3; cfg_div = 4'd0; cfg_mode = 1'b1; cfg_valid = 1'b1;
      #1;
      total_cnt++;
      if (cfg_ready !== 1'b1) begin
         $display("FAIL oor_ready got=%b want=1", cfg_ready);
      end else pass_cnt++;
      for (int k = 1; k <= 12; k++) begin
         exp_q.push_back({d(k), d(k), d(k), 3'b000});
      end
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         total_cnt++;
         if ({slow, tick} !== e) begin
            $display("FAIL oor_run k=%0d got=%b want=%b", k, {slow, tick}, e);
         end else pass_cnt++;
         if (k == 1) begin
            cfg_valid = 1'b0;
            for (int c = 0; c < 3; c++) begin
               cfg_ch = 2'(c);
               #1;
               total_cnt++;
               if (cfg_ready !== 1'b1) begin
                  $display("FAIL oor_pend ch=%0d got=%b want=1", c, cfg_ready);
               end else pass_cnt++;
            end
         end
      end
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_tick_reprogram();
      test_zero_div();
      test_disabled_cfg();
      test_terminal_cfg();
      test_sync_restart();
      test_reset_oor();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
